seq_pattern_tx: RTL



---
 rtl/seq_pkg.sv | 12 +
 rtl/seq_pattern_tx.sv | 124 ++++++++++++
 2 files changed

// File: rtl/seq_pkg.sv
// Shared state encoding and idle line level for the serial pattern
// transmitter and its companion sequence detector.
package seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, one bit per
// clock, repeated back-to-back, with busy/bit_valid framing and a done pulse.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] reps,
    output logic             w,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic               w_q, w_d;
    logic               bit_valid_q, bit_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [LEN_W-1:0]   eff_len_c;
    logic [CNT_W-1:0]   eff_reps_c;
    logic [LEN_W-1:0]   first_idx_c;
    logic [LEN_W-1:0]   next_idx_c;

    // Out-of-range length and zero repeat count fall back to full width / one rep.
    always_comb begin
        eff_len_c   = (len == '0 || len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
        eff_reps_c  = (reps == '0) ? CNT_W'(1) : reps;
        first_idx_c = eff_len_c - LEN_W'(1);
        next_idx_c  = idx_q - LEN_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        len_d       = len_q;
        idx_d       = idx_q;
        rep_d       = rep_q;
        w_d         = w_q;
        bit_valid_d = bit_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_d         = IDLE_LEVEL;
                bit_valid_d = 1'b0;
                busy_d      = 1'b0;
                if (load) begin
                    state_d     = ST_SEND;
                    sreg_d      = data;
                    len_d       = eff_len_c;
                    idx_d       = first_idx_c;
                    rep_d       = eff_reps_c;
                    w_d         = data[IDX_W'(first_idx_c)];
                    bit_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ST_SEND: begin
                // idx_q is the index of the bit currently on w.
                if (idx_q != '0) begin
                    idx_d = next_idx_c;
                    w_d   = sreg_q[IDX_W'(next_idx_c)];
                end else if (rep_q > CNT_W'(1)) begin
                    rep_d = rep_q - CNT_W'(1);
                    idx_d = len_q - LEN_W'(1);
                    w_d   = sreg_q[IDX_W'(len_q - LEN_W'(1))];
                end else begin
                    state_d     = ST_IDLE;
                    w_d         = IDLE_LEVEL;
                    bit_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            rep_q       <= '0;
            w_q         <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            rep_q       <= rep_d;
            w_q         <= w_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign w         = w_q;
    assign bit_valid = bit_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
